// File: rtl/cplx_mult_seq_pkg.sv
// Shared Q15.16 constants and FSM state type for the sequenced complex multiplier.
// Optional accumulator states are used only when CPLX_MULT_SEQ_ACCUM_EN is defined.
package cplx_pkg;

  localparam int Q_W    = 32;
  localparam int Q_FRAC = 16;

  localparam logic [Q_W-1:0] Q_ONE = 32'h0001_0000;
  localparam logic [Q_W-1:0] Q_MAX = 32'h7FFF_FFFF;
  localparam logic [Q_W-1:0] Q_MIN = 32'h8000_0000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_M0,
    S_M1,
    S_M2A0,
    S_M3,
    S_A1,
    S_ACC0,
    S_ACC1,
    S_DONE
  } cplx_state_t;

endpackage

// File: rtl/cplx_mult_seq_if.sv
// Operand/result handshake bundle for cplx_mult_seq.
// acc_clr exists only when CPLX_MULT_SEQ_ACCUM_EN is defined.
interface cplx_mult_seq_if;
  import cplx_pkg::*;

  logic           in_valid;
  logic           in_ready;
  logic [Q_W-1:0] a_re;
  logic [Q_W-1:0] a_im;
  logic [Q_W-1:0] b_re;
  logic [Q_W-1:0] b_im;
`ifdef CPLX_MULT_SEQ_ACCUM_EN
  logic           acc_clr;
`endif
  logic           out_valid;
  logic           out_ready;
  logic [Q_W-1:0] out_re;
  logic [Q_W-1:0] out_im;
  logic           out_ovf;
  logic           busy;

  modport master (
    output in_valid,
    output a_re,
    output a_im,
    output b_re,
    output b_im,
`ifdef CPLX_MULT_SEQ_ACCUM_EN
    output acc_clr,
`endif
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_re,
    input  out_im,
    input  out_ovf,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  a_re,
    input  a_im,
    input  b_re,
    input  b_im,
`ifdef CPLX_MULT_SEQ_ACCUM_EN
    input  acc_clr,
`endif
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_re,
    output out_im,
    output out_ovf,
    output busy
  );

endinterface

// File: rtl/fixed_point_add.sv
// Saturating signed add: one guard bit, clamp to the DATA_W signed range.
module fixed_point_add #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] y_o,
  output logic              ovf_o
);

  localparam logic [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W:0] sum;

  assign sum   = {a_i[DATA_W-1], a_i} + {b_i[DATA_W-1], b_i};
  assign ovf_o = sum[DATA_W] ^ sum[DATA_W-1];
  assign y_o   = ovf_o ? (sum[DATA_W] ? MIN_V : MAX_V)
                       : sum[DATA_W-1:0];

endmodule

// File: rtl/fixed_point_mult.sv
// Saturating signed fixed-point multiply: full product, arithmetic
// shift right by FRAC_W, clamp to the DATA_W signed range.
module fixed_point_mult #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] y_o,
  output logic              ovf_o
);

  localparam logic [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [2*DATA_W-1:0] prod;
  logic signed [2*DATA_W-1:0] shr;
  logic        [DATA_W:0]     hi;

  assign prod = $signed(a_i) * $signed(b_i);
  assign shr  = prod >>> FRAC_W;

  // Result fits only if every bit above the kept sign bit matches it.
  assign hi    = shr[2*DATA_W-1:DATA_W-1];
  assign ovf_o = !((&hi) || !(|hi));

  assign y_o = ovf_o ? (shr[2*DATA_W-1] ? MIN_V : MAX_V)
                     : shr[DATA_W-1:0];

endmodule

// File: rtl/q_sat_neg.sv
// Combinational saturating Q15.16 negate; -MIN clamps to MAX and flags overflow.
module q_sat_neg
  import cplx_pkg::*;
(
  input  logic [Q_W-1:0] x_i,
  output logic [Q_W-1:0] y_o,
  output logic           ovf_o
);

  assign ovf_o = (x_i == Q_MIN);
  assign y_o   = ovf_o ? Q_MAX : (~x_i + 1'b1);

endmodule

// File: rtl/cplx_mult_seq.sv
// Sequenced complex multiplier sharing one multiplier and one adder.
// Define CPLX_MULT_SEQ_ACCUM_EN to add the result accumulator.
module cplx_mult_seq
  import cplx_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  cplx_mult_seq_if.slave bus
);

  cplx_state_t state_q;

  logic [Q_W-1:0] a_re_q, a_im_q, b_re_q, b_im_q;
  logic [Q_W-1:0] p0_q, p1_q, p2_q, p3_q;
  logic [Q_W-1:0] re_q, im_q;
  logic           ovf_q;
  logic           out_valid_q;
`ifdef CPLX_MULT_SEQ_ACCUM_EN
  logic [Q_W-1:0] acc_re_q, acc_im_q;
  logic           acc_clr_q;
`endif

  logic [Q_W-1:0] mul_a, mul_b, mul_y;
  logic           mul_ovf;
  logic [Q_W-1:0] add_a, add_b, add_y;
  logic           add_ovf;
  logic [Q_W-1:0] neg_y;
  logic           neg_ovf;

  // Operand steering for the shared datapath, keyed by schedule slot.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    add_a = '0;
    add_b = '0;
    unique case (state_q)
      S_M0: begin
        mul_a = a_re_q;
        mul_b = b_re_q;
      end
      S_M1: begin
        mul_a = a_im_q;
        mul_b = b_im_q;
      end
      S_M2A0: begin
        mul_a = a_re_q;
        mul_b = b_im_q;
        add_a = p0_q;
        add_b = p1_q;
      end
      S_M3: begin
        mul_a = a_im_q;
        mul_b = b_re_q;
      end
      S_A1: begin
        add_a = p2_q;
        add_b = p3_q;
      end
`ifdef CPLX_MULT_SEQ_ACCUM_EN
      S_ACC0: begin
        add_a = acc_clr_q ? '0 : acc_re_q;
        add_b = re_q;
      end
      S_ACC1: begin
        add_a = acc_clr_q ? '0 : acc_im_q;
        add_b = im_q;
      end
`endif
      default: begin
        mul_a = '0;
      end
    endcase
  end

  fixed_point_mult #(
    .DATA_W(DATA_W),
    .FRAC_W(FRAC_W)
  ) u_mult (
    .a_i  (mul_a),
    .b_i  (mul_b),
    .y_o  (mul_y),
    .ovf_o(mul_ovf)
  );

  fixed_point_add #(
    .DATA_W(DATA_W)
  ) u_add (
    .a_i  (add_a),
    .b_i  (add_b),
    .y_o  (add_y),
    .ovf_o(add_ovf)
  );

  q_sat_neg u_neg (
    .x_i  (mul_y),
    .y_o  (neg_y),
    .ovf_o(neg_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_re_q      <= '0;
      a_im_q      <= '0;
      b_re_q      <= '0;
      b_im_q      <= '0;
      p0_q        <= '0;
      p1_q        <= '0;
      p2_q        <= '0;
      p3_q        <= '0;
      re_q        <= '0;
      im_q        <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef CPLX_MULT_SEQ_ACCUM_EN
      acc_re_q    <= '0;
      acc_im_q    <= '0;
      acc_clr_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_re_q  <= bus.a_re;
            a_im_q  <= bus.a_im;
            b_re_q  <= bus.b_re;
            b_im_q  <= bus.b_im;
            ovf_q   <= 1'b0;
`ifdef CPLX_MULT_SEQ_ACCUM_EN
            acc_clr_q <= bus.acc_clr;
`endif
            state_q <= S_M0;
          end
        end
        S_M0: begin
          p0_q    <= mul_y;
          ovf_q   <= ovf_q | mul_ovf;
          state_q <= S_M1;
        end
        S_M1: begin
          p1_q    <= neg_y;
          ovf_q   <= ovf_q | mul_ovf | neg_ovf;
          state_q <= S_M2A0;
        end
        S_M2A0: begin
          p2_q    <= mul_y;
          re_q    <= add_y;
          ovf_q   <= ovf_q | mul_ovf | add_ovf;
          state_q <= S_M3;
        end
        S_M3: begin
          p3_q    <= mul_y;
          ovf_q   <= ovf_q | mul_ovf;
          state_q <= S_A1;
        end
        S_A1: begin
          im_q    <= add_y;
          ovf_q   <= ovf_q | add_ovf;
`ifdef CPLX_MULT_SEQ_ACCUM_EN
          state_q <= S_ACC0;
`else
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
`endif
        end
`ifdef CPLX_MULT_SEQ_ACCUM_EN
        S_ACC0: begin
          acc_re_q <= add_y;
          ovf_q    <= ovf_q | add_ovf;
          state_q  <= S_ACC1;
        end
        S_ACC1: begin
          acc_im_q    <= add_y;
          ovf_q       <= ovf_q | add_ovf;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
`endif
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_ovf   = ovf_q;
`ifdef CPLX_MULT_SEQ_ACCUM_EN
  assign bus.out_re    = acc_re_q;
  assign bus.out_im    = acc_im_q;
`else
  assign bus.out_re    = re_q;
  assign bus.out_im    = im_q;
`endif

endmodule
